// File: rtl/axil_param_regfile.sv
// AXI4-Lite register file with per-register hardware load port and AXI write strobes.
// Optional macro AXIL_REGFILE_SLVERR_EN: SLVERR on out-of-range accesses and read-only writes.

module axil_param_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                                 S_AXI_AWPROT,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                                 S_AXI_ARPROT,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   regs_out,
    input  logic [C_NUM_REGS-1:0]                      hw_we,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_wdata,
    output logic [C_NUM_REGS-1:0]                      wr_pulse
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NB       = DW / 8;
    localparam int unsigned NR       = C_NUM_REGS;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned ADDR_LSB = $clog2(NB);
    localparam int unsigned IDX_W    = $clog2(NR);
    localparam int unsigned IDX_TOP  = ADDR_LSB + IDX_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    // Any set bit above the index field lands outside the register window.
    function automatic logic addr_oor(input logic [AW-1:0] a);
        return (a >> IDX_TOP) != '0;
    endfunction

    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];
    logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic          aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
    logic          bvalid_q, bvalid_d, ar_ready_q, ar_ready_d, rvalid_q, rvalid_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NB-1:0] wstrb_q, wstrb_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [NR-1:0] wr_pulse_q, wr_pulse_d;

    logic             aw_hs, w_hs, ar_hs, commit, aw_bad, ar_oor;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_hs  = S_AXI_AWVALID & aw_ready_q;
    assign w_hs   = S_AXI_WVALID & w_ready_q;
    assign ar_hs  = S_AXI_ARVALID & ar_ready_q;
    assign commit = aw_full_q & w_full_q;
    assign aw_idx = aw_addr_q[ADDR_LSB +: IDX_W];
    assign aw_bad = addr_oor(aw_addr_q) | C_RO_MASK[aw_idx];
    assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign ar_oor = addr_oor(S_AXI_ARADDR);

    // Next-state for write slots, B channel, register array and read channel.
    always_comb begin
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        aw_addr_d  = aw_addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (SLVERR_EN && aw_bad) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        aw_ready_d = !aw_full_d && !bvalid_d;
        w_ready_d  = !w_full_d && !bvalid_d;

        // Hardware load first, so strobed AXI bytes override it on a shared edge.
        for (int unsigned i = 0; i < NR; i++) begin
            regs_d[i] = regs_q[i];
            if (hw_we[i]) regs_d[i] = hw_wdata[i*DW +: DW];
            if (commit && !aw_bad && aw_idx == IDX_W'(i)) begin
                wr_pulse_d[i] = |wstrb_q;
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wstrb_q[b]) regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                end
            end
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_oor ? '0 : regs_q[ar_idx];
            rresp_d  = (SLVERR_EN && ar_oor) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        ar_ready_d = !rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int unsigned i = 0; i < NR; i++) regs_q[i] <= '0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) regs_q[i] <= regs_d[i];
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            ar_ready_q <= ar_ready_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            aw_addr_q  <= aw_addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DW +: DW] = regs_q[g];
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: doc/axil_param_regfile.md
AXIL_PARAM_REGFILE -- requirements
Module: axil_param_regfile

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; legal values are 32 or 64.
REQ-002 The block SHALL have parameter C_NUM_REGS, default 16, register count; it is a power of two from 2 to 256.
REQ-003 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width; it is at least log2(C_NUM_REGS)+log2(C_S_AXI_DATA_WIDTH/8).
REQ-004 The block SHALL have parameter C_RO_MASK, default 0 (C_NUM_REGS bits); a set bit i makes register i read-only from AXI.
REQ-005 The block SHALL have these ports (one clock; reset asynchronous, active-high):
 S_AXI_ACLK  in  1  clock
 S_AXI_ARESET  in  1  asynchronous active-high reset
 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
 S_AXI_AWPROT  in  3  ignored
 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
 S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
 S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables
 S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
 S_AXI_BRESP  out  2  write response
 S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
 S_AXI_ARPROT  in  3  ignored
 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
 S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
 S_AXI_RRESP  out  2  read response
 S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
 regs_out  out  C_NUM_REGS*C_S_AXI_DATA_WIDTH  flat register contents; register i occupies slice i
 hw_we  in  C_NUM_REGS  hardware load enable per register
 hw_wdata  in  C_NUM_REGS*C_S_AXI_DATA_WIDTH  hardware load data; slice i feeds register i
 wr_pulse  out  C_NUM_REGS  one-cycle strobe on an AXI write commit

Function
REQ-006 Decode SHALL be: ADDR_LSB = log2(DATA_WIDTH/8); index = addr[ADDR_LSB +: log2(C_NUM_REGS)]; any set address bit above the index field makes the access out-of-range; bits below ADDR_LSB are ignored.
REQ-007 AW and W SHALL be captured independently into one-entry holding slots, in either order or in the same cycle.
REQ-008 AWREADY (and likewise WREADY) SHALL be registered and high only while its own slot is empty and BVALID=0.
REQ-009 Commit SHALL occur on the first edge at which both slots are full; at that edge the target register is byte-merged by WSTRB, BVALID rises, and both slots clear.
REQ-010 BVALID SHALL hold with BRESP stable until BREADY; a new AW/W is not accepted while BVALID=1.
REQ-011 A write to a C_RO_MASK register or to an out-of-range address SHALL leave all registers unchanged and still complete with a B response.
REQ-012 wr_pulse[i] SHALL be high for exactly the one cycle after a commit to writable, in-range register i; it stays low for WSTRB=0 writes.
REQ-013 ARREADY SHALL be high only while RVALID=0; RDATA SHALL be registered on the cycle after the AR handshake and held with RVALID until RREADY.
REQ-014 An out-of-range read SHALL return RDATA=0.
REQ-015 hw_we[i] SHALL load slice i of hw_wdata into register i on the next edge; this applies to RO registers too.
REQ-016 When an AXI commit and hw_we target the same register on the same edge, the AXI strobed bytes SHALL win and the unstrobed bytes SHALL take hw_wdata.
REQ-017 A read and a commit to the same register on the same edge SHALL return the pre-commit value.
REQ-018 The write and read paths SHALL operate concurrently; there is at most one outstanding write and one outstanding read.

Reset
REQ-019 While S_AXI_ARESET=1, all registers, slots, readies, BVALID, RVALID, RDATA, wr_pulse SHALL be 0 and BRESP=RRESP=OKAY.
REQ-020 AWREADY, WREADY and ARREADY SHALL rise on the first edge after reset deasserts.
REQ-021 A transaction in flight at reset assertion SHALL be discarded without a response.

Configuration
REQ-022 With macro AXIL_REGFILE_SLVERR_EN defined, out-of-range reads and writes, and writes to RO registers, SHALL respond SLVERR (2'b10); all other accesses respond OKAY.
REQ-023 With AXIL_REGFILE_SLVERR_EN undefined, every response SHALL be OKAY; data behaviour is identical in both builds.

Verification
REQ-024 Defaults: write 0x1,0x2,0x3,0x4 to 0x00..0x0C, read back -> identical data, BRESP=RRESP=OKAY, wr_pulse[0..3] each pulse once.
REQ-025 W issued 3 cycles before AW to 0x08 with data 0xA5A5A5A5 -> single commit, reg2=0xA5A5A5A5, BVALID once.
REQ-026 reg1=0x11223344, then write 0xFFFFFFFF with WSTRB=4'b0101 -> readback 0x11FF33FF.
REQ-027 C_RO_MASK bit 3 set, hw_we[3] loads 0xDEADBEEF, then AXI writes 0 to 0x0C -> reads 0xDEADBEEF; BRESP=SLVERR with macro defined, OKAY without.
REQ-028 Read 0x40 with 16 regs -> RDATA=0, RRESP=SLVERR with macro defined; BREADY held low 10 cycles -> BVALID stays high and AWREADY stays low throughout.
REQ-029 Reset asserted mid-write after AW only -> no BVALID, regs 0, readies high one cycle after release.
